// File: rtl/vga_scanout.sv
// VGA scanout: generates 640x480@60 timing from the 50 MHz clock and reads the 160x120 3-bit framebuffer.
// Each framebuffer word covers a 4x4 screen block; pins are registered one pixel period behind the counters.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [14:0] mem_address,
    input  logic [2:0]  mem_q,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic        VGA_CLK,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic       pix_en_q, pix_en_d;
    logic       vga_clk_q, vga_clk_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       frame_start_q, frame_start_d;
    logic [9:0] r_q, r_d;
    logic [9:0] g_q, g_d;
    logic [9:0] b_q, b_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;

    logic        active;
    logic        hs_raw;
    logic        vs_raw;
    logic [9:0]  blk_row;
    logic [9:0]  blk_col;
    logic [14:0] row_ext;
    logic [14:0] row_base;

    // Pixel-rate enable, the delayed copy that drives VGA_CLK, and the raster counters.
    always_comb begin
        pix_en_d      = !pix_en_q;
        vga_clk_d     = pix_en_q;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_comb begin
        active = (h_q < H_VIS) && (v_q < V_VIS);
        hs_raw = !((h_q >= HS_START) && (h_q <= HS_END));
        vs_raw = !((v_q >= VS_START) && (v_q <= VS_END));
    end

    // Row stride of 160 words is built as (row << 7) + (row << 5).
    always_comb begin
        blk_row     = v_q >> 2;
        blk_col     = h_q >> 2;
        row_ext     = {5'd0, blk_row};
        row_base    = (row_ext << 7) + (row_ext << 5);
        mem_address = '0;
        if (active) begin
            mem_address = row_base + {5'd0, blk_col};
        end
    end

    // Output stage captures RAM data and the sync/active state of the pixel the counters are leaving.
    always_comb begin
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        if (pix_en_q) begin
            r_d     = active ? {10{mem_q[2]}} : '0;
            g_d     = active ? {10{mem_q[1]}} : '0;
            b_d     = active ? {10{mem_q[0]}} : '0;
            hs_d    = hs_raw;
            vs_d    = vs_raw;
            blank_d = active;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            vga_clk_q     <= vga_clk_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign VGA_SYNC    = 1'b1;
    assign VGA_CLK     = vga_clk_q;
    assign frame_start = frame_start_q;

endmodule
